// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed from a circular input FIFO
module uart_tx_fifo #(
  parameter int CLOCK_HZ  = 10_000,
  parameter int UART_BAUD = 1_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_AW:0]     level,
  output logic                 busy,
  output logic                 ovf,
  input  logic                 clr_ovf,
  output logic                 uart_tx
);
  localparam int DIV = CLOCK_HZ / UART_BAUD;
  localparam int CW = $clog2(DIV);
  localparam int LW = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4;
  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_AW < 1) begin : g_bad_params
    $fatal(1, "uart_tx_fifo: illegal parameter combination");
  end
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wp, rp;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] sh, head;
  logic                 par, push, pop, tick;
  logic [LW-1:0]        lvl_n;
  always_comb begin
    tick = cnt == CW'(DIV - 1);
    head = mem[rp];
    push = wr && !full;
    pop = !empty && (state == IDLE || (state == STOP && tick && idx == 4'(STOP_BITS - 1)));
    lvl_n = level + LW'(push) - LW'(pop);
  end
  assign busy = state != IDLE || !empty;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      ovf <= 1'b0;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      state <= IDLE;
      uart_tx <= 1'b1;
    end else begin
      wp <= wp + FIFO_AW'(push);
      rp <= rp + FIFO_AW'(pop);
      level <= lvl_n;
      full <= lvl_n == LW'(DEPTH);
      empty <= lvl_n == '0;
      ovf <= (wr && full) ? 1'b1 : clr_ovf ? 1'b0 : ovf;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      // parity is taken from the whole word at load time, before shifting starts
      if (pop) begin
        sh <= head;
        par <= (PARITY == 2) ? ^head : ~^head;
      end
      case (state)
        IDLE: if (pop) begin
          state <= START;
          uart_tx <= 1'b0;
        end
        START: if (tick) begin
          state <= DATA;
          idx <= '0;
          uart_tx <= sh[0];
        end
        DATA: if (tick) begin
          if (idx == 4'(DATA_BITS - 1)) begin
            state <= (PARITY != 0) ? PAR : STOP;
            idx <= '0;
            uart_tx <= (PARITY != 0) ? par : 1'b1;
          end else begin
            idx <= idx + 4'd1;
            sh <= sh >> 1;
            uart_tx <= sh[1];
          end
        end
        PAR: if (tick) begin
          state <= STOP;
          idx <= '0;
          uart_tx <= 1'b1;
        end
        STOP: if (tick) begin
          if (idx == 4'(STOP_BITS - 1)) begin
            idx <= '0;
            state <= pop ? START : IDLE;
            uart_tx <= !pop;
          end else idx <= idx + 4'd1;
        end
        default: begin
          state <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO overflow, reset and back-to-back frames
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr [5];
  logic clr [5];
  logic [7:0] wd [5];
  logic full [5], empty [5], busy [5], ovf [5], tx [5];
  logic [4:0] lv0, lv1, lv2, lv3;
  logic [2:0] lv4;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [7:0] d;
    logic [9:0] f;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  uart_tx_fifo u0 (.clk(clk), .rst(rst), .wr(wr[0]), .wr_data(wd[0]), .full(full[0]), .empty(empty[0]),
    .level(lv0), .busy(busy[0]), .ovf(ovf[0]), .clr_ovf(clr[0]), .uart_tx(tx[0]));
  uart_tx_fifo #(.PARITY(2)) u1 (.clk(clk), .rst(rst), .wr(wr[1]), .wr_data(wd[1]), .full(full[1]),
    .empty(empty[1]), .level(lv1), .busy(busy[1]), .ovf(ovf[1]), .clr_ovf(clr[1]), .uart_tx(tx[1]));
  uart_tx_fifo #(.PARITY(1)) u2 (.clk(clk), .rst(rst), .wr(wr[2]), .wr_data(wd[2]), .full(full[2]),
    .empty(empty[2]), .level(lv2), .busy(busy[2]), .ovf(ovf[2]), .clr_ovf(clr[2]), .uart_tx(tx[2]));
  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .wr(wr[3]), .wr_data(wd[3][6:0]),
    .full(full[3]), .empty(empty[3]), .level(lv3), .busy(busy[3]), .ovf(ovf[3]), .clr_ovf(clr[3]),
    .uart_tx(tx[3]));
  uart_tx_fifo #(.FIFO_AW(2)) u4 (.clk(clk), .rst(rst), .wr(wr[4]), .wr_data(wd[4]), .full(full[4]),
    .empty(empty[4]), .level(lv4), .busy(busy[4]), .ovf(ovf[4]), .clr_ovf(clr[4]), .uart_tx(tx[4]));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // f[b] is the b-th bit on the line; checks first and last clock of each 10-clock bit
  task automatic sample_frame(input int k, input logic [15:0] f, input int n);
    for (int b = 0; b < n; b++)
      for (int j = 0; j < 10; j++) begin
        if (j == 0 || j == 9) chk($sformatf("tx%0d_bit%0d_clk%0d", k, b, j), int'(tx[k]), int'(f[b]));
        @(negedge clk);
      end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    wr[k] = 1'b1;
    wd[k] = d;
    @(negedge clk);
    wr[k] = 1'b0;
    chk($sformatf("empty%0d_after_push", k), int'(empty[k]), 0);
    chk($sformatf("tx%0d_high_before_pop", k), int'(tx[k]), 1);
    @(negedge clk);
    chk($sformatf("busy%0d_at_start", k), int'(busy[k]), 1);
  endtask

  initial begin
    tbl[0] = '{8'h41, 10'h282};
    tbl[1] = '{8'h00, 10'h200};
    tbl[2] = '{8'hFF, 10'h3FE};
    tbl[3] = '{8'hA5, 10'h34A};
    tbl[4] = '{8'h5A, 10'h2B4};
    for (int k = 0; k < 5; k++) begin
      wr[k] = 1'b0;
      clr[k] = 1'b0;
      wd[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rst_tx%0d", k), int'(tx[k]), 1);
      chk($sformatf("rst_empty%0d", k), int'(empty[k]), 1);
      chk($sformatf("rst_full%0d", k), int'(full[k]), 0);
      chk($sformatf("rst_busy%0d", k), int'(busy[k]), 0);
      chk($sformatf("rst_ovf%0d", k), int'(ovf[k]), 0);
    end
    chk("rst_level0", int'(lv0), 0);
    chk("rst_level4", int'(lv4), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      push(0, tbl[i].d);
      chk($sformatf("level0_after_pop_v%0d", i), int'(lv0), 0);
      sample_frame(0, 16'(tbl[i].f), 10);
      chk($sformatf("busy0_end_v%0d", i), int'(busy[0]), 0);
      chk($sformatf("tx0_idle_v%0d", i), int'(tx[0]), 1);
    end

    push(1, 8'h41);
    sample_frame(1, 16'({1'b1, 1'b0, 8'h41, 1'b0}), 11);
    chk("busy1_end_110", int'(busy[1]), 0);
    push(2, 8'h41);
    sample_frame(2, 16'({1'b1, 1'b1, 8'h41, 1'b0}), 11);
    chk("busy2_end_110", int'(busy[2]), 0);

    fork
      begin
        for (int i = 0; i < 6; i++) begin
          wr[4] = 1'b1;
          wd[4] = 8'(8'h10 + i);
          @(negedge clk);
          if (i == 4) begin
            chk("fifo_full_after_5", int'(full[4]), 1);
            chk("fifo_ovf_clear_before_6", int'(ovf[4]), 0);
          end
        end
        wr[4] = 1'b0;
        chk("fifo_full", int'(full[4]), 1);
        chk("fifo_level4", int'(lv4), 4);
        chk("fifo_ovf_set", int'(ovf[4]), 1);
        clr[4] = 1'b1;
        @(negedge clk);
        clr[4] = 1'b0;
        chk("fifo_ovf_cleared", int'(ovf[4]), 0);
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) sample_frame(4, 16'({1'b1, 8'(8'h10 + i), 1'b0}), 10);
        chk("fifo_busy_end", int'(busy[4]), 0);
        chk("fifo_empty_end", int'(empty[4]), 1);
      end
    join

    wr[3] = 1'b1;
    wd[3] = 8'h7F;
    @(negedge clk);
    wd[3] = 8'h00;
    @(negedge clk);
    wr[3] = 1'b0;
    sample_frame(3, 16'({2'b11, 7'h7F, 1'b0}), 10);
    sample_frame(3, 16'({2'b11, 7'h00, 1'b0}), 10);
    chk("busy3_end_200", int'(busy[3]), 0);

    wr[0] = 1'b1;
    wd[0] = 8'h3C;
    @(negedge clk);
    wd[0] = 8'hC3;
    @(negedge clk);
    wr[0] = 1'b0;
    fork
      begin
        repeat (99) @(negedge clk);
        wr[0] = 1'b1;
        wd[0] = 8'h96;
        @(negedge clk);
        wr[0] = 1'b0;
        chk("pushpop_level", int'(lv0), 1);
        chk("pushpop_ovf", int'(ovf[0]), 0);
      end
      begin
        sample_frame(0, 16'({1'b1, 8'h3C, 1'b0}), 10);
        sample_frame(0, 16'({1'b1, 8'hC3, 1'b0}), 10);
        sample_frame(0, 16'({1'b1, 8'h96, 1'b0}), 10);
      end
    join
    chk("pushpop_busy_end", int'(busy[0]), 0);

    wr[0] = 1'b1;
    wd[0] = 8'h41;
    @(negedge clk);
    wd[0] = 8'h42;
    @(negedge clk);
    wr[0] = 1'b0;
    repeat (35) @(negedge clk);
    chk("midframe_tx_low", int'(tx[0]), 0);
    chk("midframe_level", int'(lv0), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", int'(tx[0]), 1);
    chk("async_rst_empty", int'(empty[0]), 1);
    chk("async_rst_level", int'(lv0), 0);
    chk("async_rst_busy", int'(busy[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(0, 8'hA5);
    sample_frame(0, 16'(10'h34A), 10);
    chk("post_rst_busy_end", int'(busy[0]), 0);
    chk("post_rst_empty", int'(empty[0]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synthesizable, parametrised UART transmitter with an input FIFO. It succeeds the fixed 8N1, bench-only UART stimulus with real RTL that the MCU can also instantiate as its serial output path. Data width, parity, stop-bit count and FIFO depth are configurable. A word is pushed with a one-cycle strobe, queued, and serialised LSB-first on uart_tx at CLOCK_HZ/UART_BAUD clocks per bit.

Parameters:
CLOCK_HZ, 10_000, system clock frequency in Hz
UART_BAUD, 1_000, bit rate; DIV = CLOCK_HZ/UART_BAUD (integer division), DIV >= 2 required
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_AW, 4, FIFO depth = 2**FIFO_AW entries

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
wr  input  1  push strobe; one word per cycle when high
wr_data  input  DATA_BITS  word to queue; bit 0 is sent first
full  output  1  FIFO holds 2**FIFO_AW entries
empty  output  1  FIFO holds 0 entries
level  output  FIFO_AW+1  current FIFO occupancy
busy  output  1  high when state != IDLE or !empty
ovf  output  1  sticky: a push was dropped
clr_ovf  input  1  clears ovf
uart_tx  output  1  serial line, idle high, registered

Behaviour:
- Reset (async, immediate): uart_tx=1, state=IDLE, FIFO pointers=0, level=0, empty=1, full=0, busy=0, ovf=0, baud counter=0. If reset arrives mid-frame, the frame is abandoned and the line returns high at once.
- FIFO: circular buffer with FIFO_AW-bit read/write pointers that wrap modulo 2**FIFO_AW. level counts 0..2**FIFO_AW.
  - A push while full is dropped and sets ovf, even if a pop occurs in the same cycle.
  - A push and a pop in the same non-full cycle leave level unchanged.
  - full, empty and level are registered and valid in the cycle after the edge that changed them.
- ovf: set has priority over clr_ovf in the same cycle.
- Baud counter: counts 0..DIV-1. Each serial bit lasts exactly DIV clocks. The counter restarts at 0 on every bit transition.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: uart_tx=1. If !empty, load the head word into the shift register, pop, and go to START.
  - START: uart_tx=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0]; shift right every DIV clocks. After DATA_BITS bits, go to PAR if PARITY != 0, else STOP.
  - PAR: uart_tx = ^word for even parity, ~^word for odd parity, held for DIV clocks.
  - STOP: uart_tx=1 for STOP_BITS*DIV clocks. At the end of the last stop-bit clock:
    - if !empty, pop and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- Latency: a push on edge N into an empty FIFO with state IDLE is popped on edge N+1, and uart_tx falls after edge N+1. Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV clocks.
- uart_tx is driven from a flop; it has no combinational path from wr.
- Unused upper bits: none. Words are exactly DATA_BITS wide. Illegal parameter values are rejected by an elaboration-time check that stops elaboration with $fatal.

Test Plan:
- Defaults (DIV=10, 8N1), push 0x41 into an idle block -> uart_tx low after the next edge. Line sequence is 0,1,0,0,0,0,0,1,0,1, each bit held 10 clocks. busy drops 100 clocks after the pop.
- PARITY=2 then PARITY=1, push 0x41 -> parity bit 0 (even), then 1 (odd), in clocks 90..99 of the frame. Frame is 110 clocks.
- FIFO_AW=2, push 6 words 0x10..0x15 back-to-back while the transmitter is idle:
  - first word is popped immediately;
  - the next 4 are queued (full=1, level=4);
  - the 6th push is dropped and ovf=1;
  - clr_ovf clears ovf;
  - frames appear contiguously 0x10..0x14 with no idle gap.
- STOP_BITS=2, DATA_BITS=7, push 0x7F then 0x00 -> stop interval is 20 clocks high, then the second start bit. Each frame is 100 clocks.
- Assert rst at clock 35 of a frame -> uart_tx=1, empty=1, level=0 and busy=0 immediately. After release, a new push transmits a correct full frame.
- Simultaneous push and pop: level=1 and the transmitter ends a STOP bit in the same cycle as wr=1 -> level stays 1, no ovf, and the queued word is sent next.
